// File: rtl/sc_scbc_pkg.sv
// Shared types and constants for the SCBC ULPI low-level register access blocks.
package sc_scbc_pkg;

  localparam int unsigned SCBC_ULLA_AW = 8;
  localparam int unsigned SCBC_ULLA_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } scbcUllaArbState_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned scbc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_scbc_rr_arb.sv
// Round-robin picker: combinational winner search starting after the stored
// pointer, pointer moves to the winner whenever a pick is taken.
module sc_scbc_rr_arb
  import sc_scbc_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 i_req,
  input  logic                         i_en,
  output logic [N-1:0]                 o_gnt_oh_c,
  output logic [scbc_idx_w(N)-1:0]     o_gnt_idx_c
);

  localparam int unsigned IW = scbc_idx_w(N);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_gnt_oh;
  logic [IW-1:0] w_gnt_idx;
  logic          w_found;

  // Search pointer+1, pointer+2, ... wrapping modulo N.
  always_comb begin
    logic [IW-1:0] cand;
    w_gnt_oh  = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(r_ptr) + k) % N);
      if (!w_found && i_req[cand]) begin
        w_found        = 1'b1;
        w_gnt_idx      = cand;
        w_gnt_oh       = '0;
        w_gnt_oh[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IW'(N - 1);
    end else if (i_en && w_found) begin
      r_ptr <= w_gnt_idx;
    end
  end

  assign o_gnt_oh_c  = w_gnt_oh;
  assign o_gnt_idx_c = w_gnt_idx;

endmodule

// File: rtl/sc_scbc_ulla_arb.sv
// Round-robin arbiter for the single ULPI low-level register access channel.
// Optional access timeout is built when SC_SCBC_ULLA_ARB_TIMEOUT_EN is defined.
module sc_scbc_ulla_arb
  import sc_scbc_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           ULPICLK,
  input  logic                           ULPIRST,
  input  logic [NREQ-1:0]                REQ,
  input  logic [NREQ*SCBC_ULLA_AW-1:0]   REQ_ADDR,
  input  logic [NREQ-1:0]                REQ_WR0RD1,
  input  logic [NREQ*SCBC_ULLA_DW-1:0]   REQ_WRDATA,
  output logic [NREQ-1:0]                ACK,
  output logic [NREQ-1:0]                ERR,
  output logic [SCBC_ULLA_DW-1:0]        RDDATA,
  output logic [NREQ-1:0]                GRANT,
  output logic                           BUSY,
  output logic                           ULLA_REQ,
  input  logic                           ULLA_ACK,
  output logic [SCBC_ULLA_AW-1:0]        ULLA_ADDR,
  output logic                           ULLA_WR0RD1,
  output logic [SCBC_ULLA_DW-1:0]        ULLA_WRDATA,
  input  logic [SCBC_ULLA_DW-1:0]        URC_DATA
);

  localparam int unsigned IW = scbc_idx_w(NREQ);
  localparam int unsigned AW = SCBC_ULLA_AW;
  localparam int unsigned DW = SCBC_ULLA_DW;

  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("sc_scbc_ulla_arb: NREQ must be 1..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sc_scbc_ulla_arb: TIMEOUT must be >= 1");
  end

  scbcUllaArbState_t r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt, r_ack, w_ack_nxt, w_win_oh;
  logic [IW-1:0]   w_win_idx;
  logic            r_busy, w_busy_nxt, r_ulla_req, w_ulla_req_nxt;
  logic            r_wr0rd1, w_wr0rd1_nxt, w_lane_wr0rd1, w_arb_en;
  logic [AW-1:0]   r_addr, w_addr_nxt, w_lane_addr;
  logic [DW-1:0]   r_wrdata, w_wrdata_nxt, w_lane_wrdata, r_rddata, w_rddata_nxt;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [NREQ-1:0] r_err, w_err_nxt;
  logic [CW-1:0]   r_tcnt, w_tcnt_nxt;
`endif

  assign w_arb_en = (r_state == IDLE);

  sc_scbc_rr_arb #(.N(NREQ)) u_rr (
    .clk         (ULPICLK),
    .rst         (ULPIRST),
    .i_req       (REQ),
    .i_en        (w_arb_en),
    .o_gnt_oh_c  (w_win_oh),
    .o_gnt_idx_c (w_win_idx)
  );

  // Only the winning lane's fields are looked at.
  always_comb begin
    w_lane_addr   = '0;
    w_lane_wrdata = '0;
    w_lane_wr0rd1 = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_lane_addr   = REQ_ADDR[i*AW +: AW];
        w_lane_wrdata = REQ_WRDATA[i*DW +: DW];
        w_lane_wr0rd1 = REQ_WR0RD1[i];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_ack_nxt      = '0;
    w_busy_nxt     = r_busy;
    w_ulla_req_nxt = r_ulla_req;
    w_addr_nxt     = r_addr;
    w_wr0rd1_nxt   = r_wr0rd1;
    w_wrdata_nxt   = r_wrdata;
    w_rddata_nxt   = r_rddata;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
    w_err_nxt      = '0;
    w_tcnt_nxt     = r_tcnt;
`endif
    case (r_state)
      IDLE: begin
        if (|REQ) begin
          w_state_nxt    = ISSUE;
          w_gnt_nxt      = w_win_oh;
          w_busy_nxt     = 1'b1;
          w_ulla_req_nxt = 1'b1;
          w_addr_nxt     = w_lane_addr;
          w_wr0rd1_nxt   = w_lane_wr0rd1;
          w_wrdata_nxt   = w_lane_wrdata;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
          w_tcnt_nxt     = '0;
`endif
        end
      end
      ISSUE: begin
        // An engine ack on the timeout cycle still completes normally.
        if (ULLA_ACK) begin
          w_state_nxt    = RELEASE;
          w_ack_nxt      = r_gnt;
          w_ulla_req_nxt = 1'b0;
          w_rddata_nxt   = URC_DATA;
        end
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
        else if (r_tcnt == CW'(TIMEOUT)) begin
          w_state_nxt    = RELEASE;
          w_ack_nxt      = r_gnt;
          w_err_nxt      = r_gnt;
          w_ulla_req_nxt = 1'b0;
          w_rddata_nxt   = '0;
        end else begin
          w_tcnt_nxt     = r_tcnt + CW'(1);
        end
`endif
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ULPICLK or posedge ULPIRST) begin
    if (ULPIRST) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_ulla_req <= 1'b0;
      r_addr     <= '0;
      r_wr0rd1   <= 1'b0;
      r_wrdata   <= '0;
      r_rddata   <= '0;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
      r_err      <= '0;
      r_tcnt     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      r_ulla_req <= w_ulla_req_nxt;
      r_addr     <= w_addr_nxt;
      r_wr0rd1   <= w_wr0rd1_nxt;
      r_wrdata   <= w_wrdata_nxt;
      r_rddata   <= w_rddata_nxt;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
      r_err      <= w_err_nxt;
      r_tcnt     <= w_tcnt_nxt;
`endif
    end
  end

  assign ACK         = r_ack;
  assign RDDATA      = r_rddata;
  assign GRANT       = r_gnt;
  assign BUSY        = r_busy;
  assign ULLA_REQ    = r_ulla_req;
  assign ULLA_ADDR   = r_addr;
  assign ULLA_WR0RD1 = r_wr0rd1;
  assign ULLA_WRDATA = r_wrdata;
`ifdef SC_SCBC_ULLA_ARB_TIMEOUT_EN
  assign ERR         = r_err;
`else
  assign ERR         = '0;
`endif

endmodule
